// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus a WIDTH-iteration shift-add
// unsigned multiplier, with a valid/ready handshake on both sides.
module alu_mc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EN,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [3:0] OP_MUL = 4'b0111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_hi, r_lo;
  logic [WIDTH-1:0] r_out, r_out_hi;
  logic             r_cout, r_zero, r_neg, r_ovf, r_err;

  logic             w_accept, w_is_mul, w_mul_last;
  logic [WIDTH:0]   w_sum, w_diff, w_madd;
  logic [WIDTH-1:0] w_res, w_mhi, w_mlo;
  logic             w_cout, w_ovf, w_err;

  assign w_accept   = in_valid & in_ready & EN;
  assign w_is_mul   = (select == OP_MUL);
  assign w_mul_last = (r_state == S_MUL) && (r_cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_is_mul ? S_MUL : S_DONE;
      S_MUL:  if (w_mul_last) w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  // Single-cycle ops, evaluated on the live operands at the accept edge
  always_comb begin
    w_sum  = {1'b0, A} + {1'b0, B};
    w_diff = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
    w_res  = '0;
    w_cout = 1'b0;
    w_ovf  = 1'b0;
    w_err  = 1'b0;
    case (select)
      4'b0001: begin
        w_res  = w_sum[WIDTH-1:0];
        w_cout = w_sum[WIDTH];
        w_ovf  = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0010: begin
        w_res  = w_diff[WIDTH-1:0];
        w_cout = w_diff[WIDTH];
        w_ovf  = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0011: w_res = A & B;
      4'b0100: w_res = A | B;
      4'b0101: w_res = A ^ B;
      4'b0110: w_res = ~A;
      4'b0111: w_res = '0;
      4'b1000: begin
        w_res  = {A[WIDTH-2:0], 1'b0};
        w_cout = A[WIDTH-1];
      end
      4'b1001: begin
        w_res  = {1'b0, A[WIDTH-1:1]};
        w_cout = A[0];
      end
      default: w_err = 1'b1;
    endcase
  end

  // One shift-add step: {carry, hi, lo} >> 1 after conditionally adding A to hi
  assign w_madd = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
  assign w_mhi  = w_madd[WIDTH:1];
  assign w_mlo  = {w_madd[0], r_lo[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept && w_is_mul) begin
      r_a   <= A;
      r_hi  <= '0;
      r_lo  <= B;
      r_cnt <= '0;
    end else if (r_state == S_MUL) begin
      r_hi  <= w_mhi;
      r_lo  <= w_mlo;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Result registers hold steady through DONE until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out    <= '0;
      r_out_hi <= '0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_out    <= w_res;
      r_out_hi <= '0;
      r_cout   <= w_cout;
      r_zero   <= (w_res == '0);
      r_neg    <= w_res[WIDTH-1];
      r_ovf    <= w_ovf;
      r_err    <= w_err;
    end else if (w_mul_last) begin
      r_out    <= w_mlo;
      r_out_hi <= w_mhi;
      r_cout   <= 1'b0;
      r_zero   <= ({w_mhi, w_mlo} == '0);
      r_neg    <= w_mlo[WIDTH-1];
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
    end
  end

  assign out    = r_out;
  assign out_hi = r_out_hi;
  assign cout   = r_cout;
  assign zero   = r_zero;
  assign neg    = r_neg;
  assign ovf    = r_ovf;
  assign err    = r_err;

endmodule
